bs_rr_router_bp: RTL
====================

// Module: bs_rr_router_bp
// PURPOSE
//  Next-generation bus generator/arbiter for the N-driver packet bus: pops packets from
//  per-driver input FIFOs, decodes the destination ID in the packet MSBs and pushes to
//  the destination FIFO, or to every other driver on broadcast. Adds over the previous
//  arbiter: fair round-robin grant, destination backpressure (full), invalid-ID drop.
//  Sits between the FIFOS interface and the driver/monitor agents of the bus env.
// PARAMETERS
//  bits       1      bus instances; only 1 supported, any other value is $fatal at elab
//  drvrs      4      number of drivers/ports, 2..16
//  pckg_sz    16     packet width; [pckg_sz-1 -: ID_W] = dest ID, rest = payload
//  ID_W       8      destination ID field width, ID_W < pckg_sz
//  broadcast  8'hFF  ID value meaning "all drivers except source"
// PORTS
//  clk     in   1              clock, rising edge
//  reset   in   1              async, active-high
//  pndng   in   drvrs          source FIFO i non-empty; D_pop[i] valid (show-ahead)
//  D_pop   in   drvrs*pckg_sz  head-of-FIFO data, lane i = [i*pckg_sz +: pckg_sz]
//  pop     out  drvrs          one-hot, 1-cycle pop strobe to source FIFO
//  full    in   drvrs          destination FIFO i cannot accept a push
//  push    out  drvrs          push strobe(s) to destination FIFOs
//  D_push  out  drvrs*pckg_sz  packet copied to every lane while push asserted
//  busy    out  1              FSM not in IDLE
//  drop    out  1              1-cycle pulse: packet discarded for invalid ID
// BEHAVIOUR
//  Reset (async assert, sync release): pop=0, push=0, D_push=0, busy=0, drop=0, FSM=IDLE,
//   rr_ptr=drvrs-1 (driver 0 has first priority), pkt_reg=0, src_reg=0.
//  FSM IDLE: if |pndng, grant g = first set pndng bit searching rr_ptr+1 upward with wrap
//   modulo drvrs; latch g into src_reg; rr_ptr<=g; -> POP. Else stay.
//  POP (1 cycle): pop[src_reg]=1; pkt_reg<=D_pop lane src_reg; -> ROUTE.
//  ROUTE (1 cycle): id = pkt_reg[pckg_sz-1 -: ID_W];
//   id==broadcast     -> dmask = all ones with bit src_reg cleared;
//   id<drvrs          -> dmask = 1<<id (self-send allowed, id==src_reg);
//   else              -> drop=1 next cycle, -> IDLE, nothing pushed.
//   valid -> WAIT.
//  WAIT: if (dmask & full)==0 -> push=dmask, D_push=pkt_reg on all lanes for exactly
//   1 cycle, -> IDLE. Else hold, no partial broadcast: all targets pushed same cycle.
//  Latency: pndng seen in cycle 0 -> pop in cycle 1 -> push earliest cycle 3 (registered
//   outputs). Min 4 cycles per packet; one packet in flight at a time.
//  pop and push never asserted in the same cycle; pop never issued while pndng[g]=0.
//  pndng dropping between IDLE and POP: grant cancelled, -> IDLE, no pop, rr_ptr kept.
//  D_push holds last pushed packet between pushes (not cleared except on reset).
//  Reset mid-op: in-flight packet lost, strobes drop immediately, rr_ptr reinitialised.
//  WAIT has no timeout; persistent full stalls the bus (busy stays 1).
// CONFIGURATION
//  BS_PKT_CNT_EN defined: adds output pkt_cnt [drvrs*16], per-destination 16-bit count of
//   packets pushed (broadcast increments every target), wraps 16'hFFFF->0, reset to 0;
//   adds output drop_cnt [16], counts drop pulses, wraps likewise.
//  BS_PKT_CNT_EN undefined: ports absent, no counters, behaviour otherwise identical.
// TESTING
//  1 drvrs=4: pndng[1]=1, D_pop[1]=16'h02A5 -> pop[1] 1 cyc, then push=4'b0100,
//    D_push lane2=16'h02A5, 3 cycles after pndng.
//  2 pndng[3]=1, pkt 16'hFF3C -> push=4'b0111 single cycle, all lanes 16'hFF3C.
//  3 pndng=4'b1111 constantly after reset -> grant order 0,1,2,3,0 (pop one-hot sequence).
//  4 pkt 16'h0211 from drv0, full[2]=1 for 20 cycles -> push held, busy=1; push=4'b0100
//    the cycle after full[2] falls.
//  5 pkt 16'h0700 (drvrs=4) -> pop then drop pulse, push stays 0; with BS_PKT_CNT_EN,
//    drop_cnt=1.
//  6 reset asserted in WAIT -> pop/push/busy=0 same cycle; after release, pndng=4'b1010
//    -> first grant driver 1.

Source files
------------

// File: rtl/bs_rr_router_bp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bs_rr_router_bp                                              |
// | Description : Round-robin packet bus router with destination backpressure  |
// |               and invalid-ID drop. Define BS_PKT_CNT_EN to add counters.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bs_rr_router_bp #(
    parameter int              BITS      = 1,
    parameter int              DRVRS     = 4,
    parameter int              PCKG_SZ   = 16,
    parameter int              ID_W      = 8,
    parameter logic [ID_W-1:0] BROADCAST = '1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DRVRS-1:0]         pndng,
    input  logic [DRVRS*PCKG_SZ-1:0] D_pop,
    output logic [DRVRS-1:0]         pop,
    input  logic [DRVRS-1:0]         full,
    output logic [DRVRS-1:0]         push,
    output logic [DRVRS*PCKG_SZ-1:0] D_push,
    output logic                     busy,
    output logic                     drop
`ifdef BS_PKT_CNT_EN
    ,
    output logic [DRVRS*16-1:0]      pkt_cnt,
    output logic [15:0]              drop_cnt
`endif
);

    localparam int c_ptr_w = (DRVRS > 1) ? $clog2(DRVRS) : 1;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_pop   = 2'd1;
    localparam logic [1:0] c_route = 2'd2;
    localparam logic [1:0] c_wait  = 2'd3;

    generate
        if (BITS != 1) begin : g_bits_check
            $fatal(1, "bs_rr_router_bp: only BITS=1 is supported");
        end
        if (DRVRS < 2 || DRVRS > 16) begin : g_drvrs_check
            $fatal(1, "bs_rr_router_bp: DRVRS must be 2..16");
        end
        if (ID_W >= PCKG_SZ) begin : g_idw_check
            $fatal(1, "bs_rr_router_bp: ID_W must be smaller than PCKG_SZ");
        end
    endgenerate

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [c_ptr_w-1:0]       r_rr_ptr;
    logic [c_ptr_w-1:0]       r_src;
    logic [c_ptr_w-1:0]       w_grant;
    logic                     w_grant_vld;
    int                       w_idx;
    logic [PCKG_SZ-1:0]       r_pkt;
    logic [DRVRS-1:0]         r_dmask;
    logic [DRVRS-1:0]         w_dmask_nxt;
    logic [DRVRS-1:0]         r_push;
    logic [DRVRS-1:0]         w_push_nxt;
    logic [DRVRS-1:0]         w_mask;
    logic [DRVRS-1:0]         w_src_1h;
    logic [ID_W-1:0]          w_id;
    logic                     w_id_bcast;
    logic                     w_id_ok;
    logic                     w_drop_nxt;
    logic                     r_drop;
    logic [DRVRS*PCKG_SZ-1:0] r_dpush;

    // Round-robin search from r_rr_ptr+1 upward; descending scan lets the nearest hit win.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = r_rr_ptr;
        w_idx       = 0;
        for (int k = DRVRS; k >= 1; k--) begin
            w_idx = (int'(r_rr_ptr) + k) % DRVRS;
            if (pndng[c_ptr_w'(w_idx)]) begin
                w_grant_vld = 1'b1;
                w_grant     = c_ptr_w'(w_idx);
            end
        end
    end

    assign w_id       = r_pkt[PCKG_SZ-1 -: ID_W];
    assign w_src_1h   = DRVRS'(1) << r_src;
    assign w_id_bcast = (w_id == BROADCAST);
    assign w_id_ok    = (32'(w_id) < 32'(DRVRS));

    always_comb begin
        w_mask = '0;
        if (w_id_bcast) begin
            w_mask = ~w_src_1h;
        end else if (w_id_ok) begin
            w_mask = DRVRS'(1) << w_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dmask_nxt = r_dmask;
        w_push_nxt  = '0;
        w_drop_nxt  = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_grant_vld) begin
                    w_state_nxt = c_pop;
                end
            end
            c_pop: begin
                // A source that went empty after the grant cancels the transfer.
                w_state_nxt = pndng[r_src] ? c_route : c_idle;
            end
            c_route: begin
                if (w_id_bcast || w_id_ok) begin
                    w_state_nxt = c_wait;
                    w_dmask_nxt = w_mask;
                    if ((w_mask & full) == '0) begin
                        w_push_nxt = w_mask;
                    end
                end else begin
                    w_state_nxt = c_idle;
                    w_drop_nxt  = 1'b1;
                end
            end
            c_wait: begin
                // All targets are pushed together; a single full target holds the lot.
                if (r_push != '0) begin
                    w_state_nxt = c_idle;
                end else if ((r_dmask & full) == '0) begin
                    w_push_nxt = r_dmask;
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= c_ptr_w'(DRVRS - 1);
            r_src    <= '0;
            r_pkt    <= '0;
            r_dmask  <= '0;
            r_push   <= '0;
            r_drop   <= 1'b0;
            r_dpush  <= '0;
        end else begin
            if (r_state == c_idle && w_grant_vld) begin
                r_src    <= w_grant;
                r_rr_ptr <= w_grant;
            end
            if (r_state == c_pop && pndng[r_src]) begin
                r_pkt <= D_pop[r_src*PCKG_SZ +: PCKG_SZ];
            end
            r_dmask <= w_dmask_nxt;
            r_push  <= w_push_nxt;
            r_drop  <= w_drop_nxt;
            if (w_push_nxt != '0) begin
                r_dpush <= {DRVRS{r_pkt}};
            end
        end
    end

    assign pop    = (r_state == c_pop && pndng[r_src]) ? w_src_1h : '0;
    assign push   = r_push;
    assign D_push = r_dpush;
    assign busy   = (r_state != c_idle);
    assign drop   = r_drop;

`ifdef BS_PKT_CNT_EN
    logic [DRVRS*16-1:0] r_pkt_cnt;
    logic [15:0]         r_drop_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            for (int i = 0; i < DRVRS; i++) begin
                if (r_push[i]) begin
                    r_pkt_cnt[i*16 +: 16] <= r_pkt_cnt[i*16 +: 16] + 16'd1;
                end
            end
            if (r_drop) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign pkt_cnt  = r_pkt_cnt;
    assign drop_cnt = r_drop_cnt;
`else
`endif

endmodule
`default_nettype wire
